sevenseg_scan_driver: RTL and testbench



---
 rtl/sevenseg_scan_driver_if.sv | 34 +++
 rtl/sevenseg_scan_driver.sv | 196 +++++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_driver_if.sv
// Pin bundle for the multiplexed seven-segment driver.
// blink_mask exists only when SEVSEG_BLINK_EN is defined.
interface sevenseg_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp;
   logic                load;
   logic                blank_lz;
   logic                enable;
`ifdef SEVSEG_BLINK_EN
   logic [DIGITS-1:0]   blink_mask;
`endif
   logic [6:0]          seg_n;
   logic                dp_n;
   logic [DIGITS-1:0]   an_n;
   logic                frame_start;

   modport master (
`ifdef SEVSEG_BLINK_EN
      output blink_mask,
`endif
      output value, dp, load, blank_lz, enable,
      input  seg_n, dp_n, an_n, frame_start
   );

   modport slave (
`ifdef SEVSEG_BLINK_EN
      input  blink_mask,
`endif
      input  value, dp, load, blank_lz, enable,
      output seg_n, dp_n, an_n, frame_start
   );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with tear-free loading,
// leading-zero blanking and guard cycles; SEVSEG_BLINK_EN adds per-digit blinking.
module sevenseg_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 1
`ifdef SEVSEG_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 64
`endif
) (
   input logic                  clk,
   input logic                  rst_n,
   sevenseg_scan_driver_if.slave bus
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
   logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic                first_q, first_d;
   logic [6:0]          seg_n_q, seg_n_d;
   logic                dp_n_q, dp_n_d;
   logic [DIGITS-1:0]   an_n_q, an_n_d;
   logic                frame_start_q, frame_start_d;

   logic                slot_wrap, frame_wrap, frame_begin;
   logic [3:0]          cur_nib;
   logic                cur_dp, cur_blank, all_zero, blink_hide;
   logic [DIGITS-1:0]   lz;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h01;
         4'h1: decode = 7'h4F;
         4'h2: decode = 7'h12;
         4'h3: decode = 7'h06;
         4'h4: decode = 7'h4C;
         4'h5: decode = 7'h24;
         4'h6: decode = 7'h20;
         4'h7: decode = 7'h0F;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h04;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h60;
         4'hC: decode = 7'h31;
         4'hD: decode = 7'h42;
         4'hE: decode = 7'h30;
         default: decode = 7'h38;
      endcase
   endfunction

   always_comb begin
      slot_wrap   = bus.enable && (cnt_q == LAST_CNT);
      frame_wrap  = slot_wrap && (idx_q == LAST_IDX);
      frame_begin = bus.enable && (cnt_q == '0) && (idx_q == '0);

      cnt_d = cnt_q;
      idx_d = idx_q;
      if (bus.enable) cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
      if (slot_wrap)  idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

      pend_val_d = bus.load ? bus.value : pend_val_q;
      pend_dp_d  = bus.load ? bus.dp    : pend_dp_q;

      // Until the first frame starts nothing is on display, so active simply
      // tracks pending; afterwards it only changes on the DIGITS-1 -> 0 wrap.
      act_val_d = act_val_q;
      act_dp_d  = act_dp_q;
      first_d   = first_q;
      if (first_q) begin
         if (frame_begin) begin
            first_d = 1'b0;
         end else begin
            act_val_d = pend_val_d;
            act_dp_d  = pend_dp_d;
         end
      end else if (frame_wrap) begin
         act_val_d = pend_val_d;
         act_dp_d  = pend_dp_d;
      end
   end

   // lz[i]: digit i is blanked because it and everything above it is zero.
   always_comb begin
      all_zero = 1'b1;
      lz       = '0;
      for (int unsigned i = DIGITS; i > 0; i--) begin
         all_zero = all_zero && (act_val_q[4*(i-1) +: 4] == 4'h0);
         lz[i-1]  = bus.blank_lz && (i > 1) && all_zero;
      end

      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            cur_nib   = act_val_q[4*i +: 4];
            cur_dp    = act_dp_q[i];
            cur_blank = lz[i];
         end
      end
   end

`ifdef SEVSEG_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES);

   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_off_q, blink_off_d;

   // Counter holds frames seen in the current phase; the phase flips as the
   // (BLINK_FRAMES+1)-th pulse arrives so that frame takes the new phase.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
      blink_hide  = 1'b0;
      if (frame_begin) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = BW'(1);
            blink_off_d = ~blink_off_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if ((IW'(i) == idx_q) && bus.blink_mask[i] && blink_off_d) blink_hide = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
      end
   end
`else
   assign blink_hide = 1'b0;
`endif

   always_comb begin
      an_n_d        = '1;
      seg_n_d       = 7'h7F;
      dp_n_d        = 1'b1;
      frame_start_d = 1'b0;
      if (bus.enable) begin
         if ((cnt_q >= GUARD_CNT) && !blink_hide) begin
            for (int unsigned i = 0; i < DIGITS; i++) an_n_d[i] = (IW'(i) != idx_q);
         end
         seg_n_d       = cur_blank ? 7'h7F : decode(cur_nib);
         dp_n_d        = ~cur_dp;
         frame_start_d = frame_begin;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         pend_val_q    <= '0;
         pend_dp_q     <= '0;
         act_val_q     <= '0;
         act_dp_q      <= '0;
         first_q       <= 1'b1;
         seg_n_q       <= 7'h7F;
         dp_n_q        <= 1'b1;
         an_n_q        <= '1;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         pend_val_q    <= pend_val_d;
         pend_dp_q     <= pend_dp_d;
         act_val_q     <= act_val_d;
         act_dp_q      <= act_dp_d;
         first_q       <= first_d;
         seg_n_q       <= seg_n_d;
         dp_n_q        <= dp_n_d;
         an_n_q        <= an_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.seg_n       = seg_n_q;
   assign bus.dp_n        = dp_n_q;
   assign bus.an_n        = an_n_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver (DIGITS=4, REFRESH_DIV=4, GUARD=1):
// the stimulus pushes one expected output vector per clock, a monitor pops and compares.
module tb_sevenseg_scan_driver;
  localparam int D  = 4;
  localparam int RD = 4;
  localparam int G  = 1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.DIGITS(D)) bus ();

  sevenseg_scan_driver #(
    .DIGITS(D),
    .REFRESH_DIV(RD),
    .GUARD(G)
`ifdef SEVSEG_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  out_t  exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    errors = 0;

  logic [3:0][6:0] cur_seg, nxt_seg;
  logic [3:0]      cur_dpn, nxt_dpn;
  int              m_cnt, m_idx, m_pulses, m_frame;

  task automatic set_nxt(input logic [6:0] s3, s2, s1, s0, input logic [3:0] dpn);
    nxt_seg = {s3, s2, s1, s0};
    nxt_dpn = dpn;
  endtask

  task automatic set_both(input logic [6:0] s3, s2, s1, s0, input logic [3:0] dpn);
    set_nxt(s3, s2, s1, s0, dpn);
    cur_seg = nxt_seg;
    cur_dpn = nxt_dpn;
  endtask

  task automatic tick(input string tag);
    out_t e;
    @(posedge clk);
    if (!rst_n) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
      m_cnt = 0; m_idx = 0; m_pulses = 0; m_frame = 0;
    end else if (!bus.enable) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
    end else begin
      e.fs = (m_cnt == 0) && (m_idx == 0);
      if (e.fs) begin
        m_frame  = m_pulses;
        m_pulses = m_pulses + 1;
      end
      e.an  = (m_cnt < G) ? 4'hF : ~(4'b0001 << m_idx);
`ifdef SEVSEG_BLINK_EN
      if ((((m_frame / 2) % 2) == 1) && (m_idx == 0)) e.an = 4'hF;
`endif
      e.seg = cur_seg[m_idx];
      e.dp  = cur_dpn[m_idx];
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        if (m_idx == D - 1) begin
          m_idx   = 0;
          cur_seg = nxt_seg;
          cur_dpn = nxt_dpn;
        end else begin
          m_idx = m_idx + 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
  endtask

  task automatic run(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) tick(tag);
  endtask

  initial begin : monitor
    out_t  e, got;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_start};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s @%0t: an_n=%b seg_n=%h dp_n=%b fs=%b, expected an_n=%b seg_n=%h dp_n=%b fs=%b",
                   t, $time, got.an, got.seg, got.dp, got.fs, e.an, e.seg, e.dp, e.fs);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.value    = '0;
    bus.dp       = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.enable   = 1'b0;
`ifdef SEVSEG_BLINK_EN
    bus.blink_mask = 4'b0001;
`endif
    m_cnt = 0; m_idx = 0; m_pulses = 0; m_frame = 0;
    set_both(7'h01, 7'h01, 7'h01, 7'h01, 4'hF);

    run(2, "reset");
    rst_n      = 1'b1;
    bus.enable = 1'b1;

    run(5, "f0_zero");
    bus.value = 16'h1A3F; bus.dp = 4'b0100; bus.load = 1'b1;
    set_nxt(7'h4F, 7'h08, 7'h06, 7'h38, 4'b1011);
    tick("f0_load");
    bus.load = 1'b0;
    run(10, "f0_zero");

    run(5, "f1_1a3f");
    bus.value = 16'h0000; bus.dp = 4'b0000; bus.load = 1'b1;
    set_nxt(7'h01, 7'h01, 7'h01, 7'h01, 4'hF);
    tick("f1_midload");
    bus.load = 1'b0;
    run(10, "f1_old");

    run(15, "f2_zero");
    bus.value = 16'h0050; bus.load = 1'b1;
    set_nxt(7'h7F, 7'h7F, 7'h24, 7'h01, 4'hF);
    tick("f2_wrapload");
    bus.load = 1'b0;
    bus.blank_lz = 1'b1;

    run(2, "f3_lz0050");
    bus.value = 16'h0000; bus.load = 1'b1;
    set_nxt(7'h7F, 7'h7F, 7'h7F, 7'h01, 4'hF);
    tick("f3_lz0050");
    bus.load = 1'b0;
    run(13, "f3_lz0050");

    run(16, "f4_lz0000");

    run(9, "f5_pre");
    bus.enable = 1'b0;
    run(4, "f5_dark");
    bus.value = 16'h8888; bus.load = 1'b1;
    set_nxt(7'h00, 7'h00, 7'h00, 7'h00, 4'hF);
    tick("f5_darkload");
    bus.load = 1'b0;
    run(5, "f5_dark");
    bus.enable = 1'b1;
    run(7, "f5_resume");

    run(6, "f6_8888");
    rst_n = 1'b0; bus.load = 1'b1;
    tick("rst_mid");
    bus.load = 1'b0;
    rst_n    = 1'b1;
    set_both(7'h7F, 7'h7F, 7'h7F, 7'h01, 4'hF);
    run(20, "post_rst");

    @(negedge clk);
    #1;
    if (vectors == 0) begin
      errors++;
      $display("FAIL: no vectors were compared");
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL: %0d expected vectors never compared", exp_q.size());
    end
    if (miscompares != 0) begin
      errors++;
      $display("FAIL: %0d miscompares", miscompares);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
